// File: rtl/sram_arbiter.sv
// Arbiter sharing one single-port SRAM between instruction fetch (IF) and the
// data-memory stage (MEM). Accesses are serialised by a four-state FSM; read
// data comes back with a one-cycle valid pulse to the owning requester.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned RAM_LAT       = 1,
    parameter int unsigned MEM_BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    output logic                if_stall_o,
    input  logic                flush_i,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_valid_o,
    output logic                mem_stall_o,
    output logic                sram_en_o,
    output logic [DATA_W/8-1:0] sram_we_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    input  logic [DATA_W-1:0]   sram_rdata_i
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MEM_BURST_MAX + 1);
    localparam int unsigned LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_owner_mem;
    logic                r_we;
    logic                r_kill;
    logic [CNT_W-1:0]    r_burst;
    logic [LAT_W-1:0]    r_wait_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_sram_en;
    logic [SEL_W-1:0]    r_sram_we;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_wdata;

    logic w_idle;
    logic w_if_ok;
    logic w_burst_full;
    logic w_grant_mem;
    logic w_grant_if;
    logic w_wait_last;

    // A fetch raised in the same cycle as a flush is wrong-path and never granted.
    assign w_idle       = (r_state == StIdle);
    assign w_if_ok      = if_req_i & ~flush_i;
    assign w_burst_full = (r_burst == CNT_W'(MEM_BURST_MAX));
    assign w_grant_mem  = w_idle & mem_req_i & ~(w_burst_full & w_if_ok);
    assign w_grant_if   = w_idle & w_if_ok & ~w_grant_mem;
    assign w_wait_last  = (r_wait_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; arbitration only ever happens in StIdle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_mem || w_grant_if) w_state_next = StIssue;
            StIssue: w_state_next = r_we ? StDone : StWait;
            StWait:  if (w_wait_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Valid pulses and stalls; a flush during the DONE cycle also hides the fetch
    always_comb begin
        mem_valid_o = (r_state == StDone) & r_owner_mem;
        if_valid_o  = (r_state == StDone) & ~r_owner_mem & ~r_kill & ~flush_i;
        if_stall_o  = if_req_i & ~if_valid_o & ~flush_i;
        mem_stall_o = mem_req_i & ~mem_valid_o;
    end

    // Transaction latch, registered SRAM strobes, wait counter and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_mem  <= 1'b0;
            r_we         <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_wait_cnt   <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            // Strobes are high only for the ISSUE cycle that follows a grant
            r_sram_en <= 1'b0;
            r_sram_we <= '0;
            if (w_grant_mem) begin
                r_owner_mem  <= 1'b1;
                r_we         <= mem_we_i;
                r_sram_en    <= 1'b1;
                r_sram_we    <= mem_we_i ? mem_sel_i : '0;
                r_sram_addr  <= mem_addr_i;
                r_sram_wdata <= mem_wdata_i;
            end else if (w_grant_if) begin
                r_owner_mem <= 1'b0;
                r_we        <= 1'b0;
                r_sram_en   <= 1'b1;
                r_sram_addr <= if_addr_i;
            end
            if (r_state == StIssue) begin
                r_wait_cnt <= LAT_W'(RAM_LAT - 1);
            end else if (r_state == StWait && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt - LAT_W'(1);
            end
            // Killed fetches still capture; only the valid pulse is suppressed
            if (r_state == StWait && w_wait_last) begin
                if (r_owner_mem) begin
                    r_mem_rdata <= sram_rdata_i;
                end else begin
                    r_if_rdata <= sram_rdata_i;
                end
            end
        end
    end

    // Consecutive MEM grants that made a waiting IF lose; saturates at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst <= '0;
        end else if (w_idle) begin
            if (w_grant_if || !if_req_i) begin
                r_burst <= '0;
            end else if (w_grant_mem && !w_burst_full) begin
                r_burst <= r_burst + CNT_W'(1);
            end
        end
    end

    // Kill flag for an IF transaction overtaken by a branch flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kill <= 1'b0;
        end else if (r_state == StDone) begin
            r_kill <= 1'b0;
        end else if (!w_idle && !r_owner_mem && flush_i) begin
            r_kill <= 1'b1;
        end
    end

    assign if_rdata_o   = r_if_rdata;
    assign mem_rdata_o  = r_mem_rdata;
    assign sram_en_o    = r_sram_en;
    assign sram_we_o    = r_sram_we;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance a uses RAM_LAT=1, instance b RAM_LAT=3.
module tb_sram_arbiter;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    // Instance a signals (RAM_LAT=1, MEM_BURST_MAX=4)
    logic        a_if_req, a_if_valid, a_if_stall, a_flush;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_mem_req, a_mem_we, a_mem_valid, a_mem_stall;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_sel, a_sram_we;
    logic        a_sram_en;
    logic [31:0] a_sram_addr, a_sram_wdata, a_sram_rdata;

    // Instance b signals (RAM_LAT=3)
    logic        b_if_req, b_if_valid, b_if_stall, b_flush;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_mem_req, b_mem_we, b_mem_valid, b_mem_stall;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_sel, b_sram_we;
    logic        b_sram_en;
    logic [31:0] b_sram_addr, b_sram_wdata, b_sram_rdata;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MEM_BURST_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_rdata_o(a_if_rdata),
        .if_valid_o(a_if_valid), .if_stall_o(a_if_stall), .flush_i(a_flush),
        .mem_req_i(a_mem_req), .mem_we_i(a_mem_we), .mem_addr_i(a_mem_addr),
        .mem_wdata_i(a_mem_wdata), .mem_sel_i(a_mem_sel), .mem_rdata_o(a_mem_rdata),
        .mem_valid_o(a_mem_valid), .mem_stall_o(a_mem_stall),
        .sram_en_o(a_sram_en), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
        .sram_wdata_o(a_sram_wdata), .sram_rdata_i(a_sram_rdata)
    );

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .MEM_BURST_MAX(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata),
        .if_valid_o(b_if_valid), .if_stall_o(b_if_stall), .flush_i(b_flush),
        .mem_req_i(b_mem_req), .mem_we_i(b_mem_we), .mem_addr_i(b_mem_addr),
        .mem_wdata_i(b_mem_wdata), .mem_sel_i(b_mem_sel), .mem_rdata_o(b_mem_rdata),
        .mem_valid_o(b_mem_valid), .mem_stall_o(b_mem_stall),
        .sram_en_o(b_sram_en), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
        .sram_wdata_o(b_sram_wdata), .sram_rdata_i(b_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed read contents of the SRAM model
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h1c00_0000: rom = 32'h0280_0413;
            32'h0000_0100: rom = 32'h1111_1111;
            32'h0000_0200: rom = 32'h2222_2222;
            32'h0000_0040: rom = 32'h1234_5678;
            default:       rom = 32'ha5a5_a5a5;
        endcase
    endfunction

    // SRAM models: data is only presented exactly RAM_LAT cycles after the strobe
    logic        a_rvld = 1'b0;
    logic [31:0] a_rdat = '0;
    always @(posedge clk) begin
        a_rvld <= a_sram_en && (a_sram_we == '0);
        a_rdat <= rom(a_sram_addr);
    end
    assign a_sram_rdata = a_rvld ? a_rdat : 32'hbad0_bad0;

    logic [2:0]  b_vld = '0;
    logic [31:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;
    always @(posedge clk) begin
        b_vld <= {b_vld[1:0], b_sram_en && (b_sram_we == '0)};
        b_d0  <= rom(b_sram_addr);
        b_d1  <= b_d0;
        b_d2  <= b_d1;
    end
    assign b_sram_rdata = b_vld[2] ? b_d2 : 32'hbad0_bad0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        a_if_req = 0; a_if_addr = '0; a_flush = 0;
        a_mem_req = 0; a_mem_we = 0; a_mem_addr = '0; a_mem_wdata = '0; a_mem_sel = '0;
        b_if_req = 0; b_if_addr = '0; b_flush = 0;
        b_mem_req = 0; b_mem_we = 0; b_mem_addr = '0; b_mem_wdata = '0; b_mem_sel = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_sram_en", 32'(a_sram_en), 0);
        check_eq("rst_sram_we", 32'(a_sram_we), 0);
        check_eq("rst_sram_addr", a_sram_addr, 0);
        check_eq("rst_if_valid", 32'(a_if_valid), 0);
        check_eq("rst_mem_valid", 32'(a_mem_valid), 0);
        check_eq("rst_if_rdata", a_if_rdata, 0);
        check_eq("rst_b_mem_rdata", b_mem_rdata, 0);
        step();
        step();
        rst = 1'b1;
        step();

        // Latency with RAM_LAT=3: MEM read at 0x40
        b_mem_req = 1; b_mem_we = 0; b_mem_addr = 32'h40; b_mem_sel = 4'hf;
        #1;
        check_eq("lat_c0_mem_stall", 32'(b_mem_stall), 1);
        step();
        check_eq("lat_c1_sram_en", 32'(b_sram_en), 1);
        check_eq("lat_c1_sram_addr", b_sram_addr, 32'h40);
        for (int c = 2; c <= 4; c++) begin
            step();
            check_eq($sformatf("lat_c%0d_mem_valid", c), 32'(b_mem_valid), 0);
        end
        step();
        check_eq("lat_c5_mem_valid", 32'(b_mem_valid), 1);
        check_eq("lat_c5_mem_rdata", b_mem_rdata, 32'h1234_5678);
        b_mem_req = 0;
        for (int c = 6; c <= 9; c++) begin
            step();
            check_eq($sformatf("lat_c%0d_mem_valid", c), 32'(b_mem_valid), 0);
            check_eq($sformatf("lat_c%0d_rdata_held", c), b_mem_rdata, 32'h1234_5678);
        end

        // IF-only read
        a_if_req = 1; a_if_addr = 32'h1c00_0000;
        #1;
        check_eq("ifrd_c0_stall", 32'(a_if_stall), 1);
        check_eq("ifrd_c0_sram_en", 32'(a_sram_en), 0);
        step();
        check_eq("ifrd_c1_sram_en", 32'(a_sram_en), 1);
        check_eq("ifrd_c1_sram_addr", a_sram_addr, 32'h1c00_0000);
        check_eq("ifrd_c1_sram_we", 32'(a_sram_we), 0);
        check_eq("ifrd_c1_stall", 32'(a_if_stall), 1);
        step();
        check_eq("ifrd_c2_valid", 32'(a_if_valid), 0);
        check_eq("ifrd_c2_stall", 32'(a_if_stall), 1);
        step();
        check_eq("ifrd_c3_valid", 32'(a_if_valid), 1);
        check_eq("ifrd_c3_rdata", a_if_rdata, 32'h0280_0413);
        check_eq("ifrd_c3_stall", 32'(a_if_stall), 0);
        a_if_req = 0;
        step();
        check_eq("ifrd_c4_valid", 32'(a_if_valid), 0);

        // Simultaneous IF read and MEM write: MEM first
        a_if_req = 1; a_if_addr = 32'h100;
        a_mem_req = 1; a_mem_we = 1; a_mem_addr = 32'h2000;
        a_mem_wdata = 32'hdead_beef; a_mem_sel = 4'b0011;
        #1;
        check_eq("sim_c0_mem_stall", 32'(a_mem_stall), 1);
        check_eq("sim_c0_if_stall", 32'(a_if_stall), 1);
        step();
        check_eq("sim_c1_sram_en", 32'(a_sram_en), 1);
        check_eq("sim_c1_sram_we", 32'(a_sram_we), 32'h3);
        check_eq("sim_c1_sram_addr", a_sram_addr, 32'h2000);
        check_eq("sim_c1_sram_wdata", a_sram_wdata, 32'hdead_beef);
        step();
        check_eq("sim_c2_mem_valid", 32'(a_mem_valid), 1);
        check_eq("sim_c2_mem_stall", 32'(a_mem_stall), 0);
        check_eq("sim_c2_if_valid", 32'(a_if_valid), 0);
        a_mem_req = 0; a_mem_we = 0;
        step();
        check_eq("sim_c3_sram_en", 32'(a_sram_en), 0);
        step();
        check_eq("sim_c4_sram_en", 32'(a_sram_en), 1);
        check_eq("sim_c4_sram_addr", a_sram_addr, 32'h100);
        check_eq("sim_c4_sram_we", 32'(a_sram_we), 0);
        step();
        check_eq("sim_c5_if_valid", 32'(a_if_valid), 0);
        step();
        check_eq("sim_c6_if_valid", 32'(a_if_valid), 1);
        check_eq("sim_c6_if_rdata", a_if_rdata, 32'h1111_1111);
        a_if_req = 0;
        step();

        // Starvation guard: both held, expect MEM x4 then IF then MEM
        a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h40; a_mem_sel = 4'hf;
        a_if_req = 1; a_if_addr = 32'h200;
        grants = 0;
        for (int c = 0; c < 80 && grants < 6; c++) begin
            step();
            if (a_sram_en) begin
                check_eq($sformatf("starve_grant%0d_is_if", grants),
                         32'(a_sram_addr == 32'h200), 32'(grants == 4));
                grants++;
            end
        end
        check_eq("starve_grant_count", 32'(grants), 6);
        a_mem_req = 0; a_if_req = 0;
        repeat (6) step();

        // Flush during WAIT kills the fetch
        a_if_req = 1; a_if_addr = 32'h100;
        step();
        check_eq("fl_c1_sram_en", 32'(a_sram_en), 1);
        step();
        a_flush = 1; a_if_req = 0;
        #1;
        check_eq("fl_c2_if_stall", 32'(a_if_stall), 0);
        step();
        a_flush = 0;
        #1;
        check_eq("fl_c3_if_valid", 32'(a_if_valid), 0);
        check_eq("fl_c3_if_rdata", a_if_rdata, 32'h1111_1111);
        step();
        check_eq("fl_c4_if_valid", 32'(a_if_valid), 0);
        a_if_req = 1; a_if_addr = 32'h200;
        step();
        check_eq("fl_c5_sram_en", 32'(a_sram_en), 1);
        check_eq("fl_c5_sram_addr", a_sram_addr, 32'h200);
        step();
        step();
        check_eq("fl_c7_if_valid", 32'(a_if_valid), 1);
        check_eq("fl_c7_if_rdata", a_if_rdata, 32'h2222_2222);
        a_if_req = 0;
        step();

        // Reset asserted during WAIT
        a_if_req = 1; a_if_addr = 32'h1c00_0000;
        step();
        step();
        rst = 1'b0; a_if_req = 0;
        #1;
        check_eq("mrst_sram_en", 32'(a_sram_en), 0);
        check_eq("mrst_sram_addr", a_sram_addr, 0);
        check_eq("mrst_sram_wdata", a_sram_wdata, 0);
        check_eq("mrst_if_rdata", a_if_rdata, 0);
        check_eq("mrst_mem_rdata", a_mem_rdata, 0);
        check_eq("mrst_if_stall", 32'(a_if_stall), 0);
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq($sformatf("mrst_hold%0d_if_valid", c), 32'(a_if_valid), 0);
        end
        rst = 1'b1;
        step();
        check_eq("mrst_idle_sram_en", 32'(a_sram_en), 0);
        check_eq("mrst_idle_if_valid", 32'(a_if_valid), 0);
        a_if_req = 1; a_if_addr = 32'h200;
        step();
        check_eq("mrst_rearb_sram_en", 32'(a_sram_en), 1);
        check_eq("mrst_rearb_sram_addr", a_sram_addr, 32'h200);
        step();
        step();
        check_eq("mrst_rearb_if_valid", 32'(a_if_valid), 1);
        check_eq("mrst_rearb_if_rdata", a_if_rdata, 32'h2222_2222);
        a_if_req = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port unified SRAM between the instruction-fetch requester (IF) and the data-memory requester (MEM stage).
- Serialises accesses with a small FSM and returns read data with a one-cycle valid pulse to the requester that owns the transaction.
- Drives per-requester stall outputs that the pipeline uses to freeze.
- Suppresses delivery of wrong-path fetches after a branch flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RAM_LAT, 1, SRAM read latency in cycles (must be at least 1).
- MEM_BURST_MAX, 4, maximum number of consecutive MEM grants while IF is pending before IF is forced a grant.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF read request; held until if_valid_o or flush.
- if_addr_i  in  ADDR_W  IF read address.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  one-cycle pulse; if_rdata_o is valid.
- if_stall_o  out  1  IF must hold.
- flush_i  in  1  branch taken; kill the outstanding or pending IF.
- mem_req_i  in  1  MEM request (chip enable).
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  ADDR_W  MEM address.
- mem_wdata_i  in  DATA_W  store data.
- mem_sel_i  in  DATA_W/8  byte enables.
- mem_rdata_o  out  DATA_W  load data.
- mem_valid_o  out  1  one-cycle pulse; read data valid or write done.
- mem_stall_o  out  1  MEM must hold.
- sram_en_o  out  1  SRAM access strobe.
- sram_we_o  out  DATA_W/8  byte write enables; all zero for reads.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_wdata_o  out  DATA_W  SRAM write data.
- sram_rdata_i  in  DATA_W  SRAM read data, valid RAM_LAT cycles after the cycle in which sram_en_o is high.

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE.
  - All outputs are 0: rdata, valid pulses, sram_* signals.
  - Owner, kill flag and burst counter are cleared.
  - An in-flight transaction is abandoned; no valid pulse is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE. All SRAM outputs are registered.
- IDLE: arbitrates, then latches owner, address, data, byte-enables and we.
  - mem_req_i wins, unless the burst counter equals MEM_BURST_MAX and if_req_i is high; in that case IF wins.
  - If only if_req_i is high (and flush_i is low), IF wins.
  - With no request, stay in IDLE.
  - if_req_i together with flush_i in the same cycle is not granted.
- ISSUE (exactly 1 cycle):
  - sram_en_o=1, address and wdata driven.
  - sram_we_o = mem_sel_i for a MEM write, 0 otherwise.
  - Write goes to DONE; read goes to WAIT.
- WAIT (RAM_LAT cycles, down-counter):
  - On the edge ending the last WAIT cycle, capture sram_rdata_i into the owner's rdata register, then go to DONE.
- DONE (exactly 1 cycle):
  - The owner's valid output is 1; the next state is IDLE.
  - No arbitration happens in DONE, so a request held through the valid cycle is never accepted twice.
- Latency, from the request being seen in IDLE to the valid cycle:
  - Read: RAM_LAT+2 cycles (3 at the default).
  - Write: 2 cycles.
  - Back-to-back transactions are spaced RAM_LAT+3 cycles (reads) and 3 cycles (writes).
- rdata_o holds its value until the next capture for that same owner.
- Stall outputs (combinational):
  - if_stall_o = if_req_i & ~if_valid_o & ~flush_i.
  - mem_stall_o = mem_req_i & ~mem_valid_o.
- Flush:
  - If flush_i is high while owner=IF in ISSUE, WAIT or DONE, set the kill flag.
  - The SRAM access completes and rdata is captured, but if_valid_o is forced to 0 for the DONE cycle.
  - The kill flag clears on entering IDLE.
  - flush_i has no effect on MEM transactions.
- Burst counter:
  - Increments on each MEM grant made while if_req_i is high, saturating at MEM_BURST_MAX.
  - Clears on any IF grant, and whenever if_req_i is low in IDLE.
- Simultaneous mem_req_i and if_req_i in IDLE with counter < MEM_BURST_MAX: MEM is granted and IF stalls.
- Requests are sampled only in IDLE. Changes to address or data after the grant are ignored.

Test Plan:
- IF-only read: RAM_LAT=1, if_addr_i=0x1c000000, SRAM returns 0x02800413.
  - sram_en_o high in cycle 1; if_valid_o high in cycle 3 with if_rdata_o=0x02800413.
  - if_stall_o high in cycles 0–2.
- Simultaneous requests: IF read at 0x100 and MEM write at 0x2000 (sel=4'b0011, data=0xdeadbeef).
  - MEM issues first with sram_we_o=0011 and mem_valid_o in cycle 2.
  - IF issues in cycle 4; if_valid_o in cycle 6.
- Starvation guard: MEM_BURST_MAX=4; mem_req_i and if_req_i both held continuously.
  - Grant sequence is MEM,MEM,MEM,MEM,IF,MEM…
- Flush: IF read accepted, then flush_i pulsed during WAIT.
  - if_valid_o stays 0 and the FSM returns to IDLE on schedule.
  - A following IF request at 0x200 returns correct data.
- Latency: RAM_LAT=3, MEM read at 0x40 returning 0x12345678.
  - mem_valid_o in cycle 5; mem_rdata_o=0x12345678 and held afterwards.
- Reset mid-operation: rst driven low during WAIT.
  - All outputs go to 0 immediately, with no valid pulse.
  - After release, an idle cycle is followed by normal arbitration.
